drive_command_ctrl: RTL and testbench
=====================================

// Module: drive_command_ctrl
// PURPOSE
//  Motion-command stage upstream of the 4-digit display. Accepts drive commands,
//  ramps left/right speed levels (0..7), sequences direction changes via a stop,
//  generates per-motor PWM and latches left-motor overcurrent faults.
//  speedLeft, speedRight, direction and fault feed the display's speed,
//  direction and reset inputs.
// PARAMETERS
//  RAMP_TICKS  1_000_000  clocks per ramp step (one speed level per step)
//  OC_FILTER   16         consecutive synced oc_left highs needed to declare a fault
//  PWM_DIV     1000       clocks per PWM slot (7 slots per PWM period)
// PORTS
//  clock        in   1  system clock
//  reset        in   1  synchronous, active-high reset
//  cmd_valid    in   1  command present
//  cmd_ready    out  1  stage can accept a command
//  cmd_dir      in   4  0000 stop, 1001 fwd, 0110 back, 0101 left, 1010 right
//  cmd_speedL   in   3  target left speed level
//  cmd_speedR   in   3  target right speed level
//  oc_left      in   1  left-motor overcurrent comparator (asynchronous)
//  fault_clear  in   1  one-cycle request to leave FAULT
//  speedLeft    out  3  current left speed level
//  speedRight   out  3  current right speed level
//  direction    out  4  H-bridge direction code currently applied
//  fault        out  1  overcurrent latched (drives display reset)
//  pwm_left     out  1  left motor enable PWM
//  pwm_right    out  1  right motor enable PWM
// BEHAVIOUR
//  - Reset: state=IDLE; speeds=0; direction=0000; fault=0; pwm=0; cmd_ready=1.
//    Clears the pending register, the ramp and PWM counters, and the OC filter.
//  - States: IDLE (speeds 0, dir 0000), RUN, DRAIN (ramp to 0 before a dir change), FAULT.
//  - Handshake: accept when cmd_valid & cmd_ready. cmd_ready=1 in IDLE/RUN, 0 in DRAIN/FAULT.
//  - Illegal cmd_dir values are treated as 0000. A dir of 0000 forces both targets to 0.
//  - Accepted cmd, same dir as current, or both speeds 0: load dir+targets next cycle -> RUN.
//  - Accepted cmd, different dir and any speed nonzero: targets=0, cmd held pending -> DRAIN.
//  - DRAIN: when speedLeft=speedRight=0, apply pending dir+targets on the next cycle -> RUN.
//  - RUN with dir 0000 and both speeds 0 -> IDLE.
//  - Ramp: free-running counter wraps at RAMP_TICKS-1. On the wrap cycle, each
//    side moves exactly one level toward its target. Sides ramp independently.
//    No overshoot; speed saturates at 0 and 7.
//  - PWM: slot counter (period PWM_DIV) advances a 3-bit phase 0..6 that wraps to 0.
//    pwm_x = (phase < speedX). Speed 0 gives constant low; speed 7 gives constant high.
//  - Overcurrent: 2-flop synchroniser, then a saturating count of consecutive
//    highs. Any low resets the count. On reaching OC_FILTER, next cycle:
//    state=FAULT, fault=1, speeds=0, dir=0000, pwm=0 (no ramp), pending dropped.
//  - FAULT: ignores commands. fault_clear with synced oc_left=0 -> IDLE, fault=0.
//    fault_clear while oc_left is still high is ignored.
//  - Fault detection in the same cycle as a handshake: fault wins, cmd discarded.
//  - Latency: a command to direction/target update is 1 cycle. Speed change waits
//    for the next ramp wrap.
// TESTING
//  - (RAMP_TICKS=4, PWM_DIV=2) reset -> all outputs 0, cmd_ready=1.
//  - fwd L=5 R=3 from IDLE -> direction=1001 next cycle; speedR=3 after 3 wraps,
//    speedL=5 after 5 wraps.
//  - Running fwd 5/5, cmd back 2/2 -> DRAIN, ready=0, dir stays 1001 while speeds
//    step 5..0; then dir=0110, speeds ramp to 2.
//  - oc_left high 15 cycles then low -> no fault. High 16+ cycles -> fault=1,
//    speeds 0 and dir 0000 immediately.
//  - In FAULT: cmd ignored, fault_clear with oc high -> stays. oc low + fault_clear -> IDLE.
//  - speed 3: pwm high 3 of 7 slots. speed 0/7 -> pwm constant 0/1.
//    cmd_dir 0011 -> treated as stop.

Source files
------------

// File: rtl/drive_command_ctrl_if.sv
// Command, overcurrent and status bundle of the drive command stage.
// The master drives commands and the motor sense lines; the slave is the controller.
interface drive_command_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_dir;
  logic [2:0] cmd_speedL;
  logic [2:0] cmd_speedR;
  logic       oc_left;
  logic       fault_clear;
  logic [2:0] speedLeft;
  logic [2:0] speedRight;
  logic [3:0] direction;
  logic       fault;
  logic       pwm_left;
  logic       pwm_right;

  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_speedL,
    output cmd_speedR,
    output oc_left,
    output fault_clear,
    input  cmd_ready,
    input  speedLeft,
    input  speedRight,
    input  direction,
    input  fault,
    input  pwm_left,
    input  pwm_right
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_speedL,
    input  cmd_speedR,
    input  oc_left,
    input  fault_clear,
    output cmd_ready,
    output speedLeft,
    output speedRight,
    output direction,
    output fault,
    output pwm_left,
    output pwm_right
  );
endinterface

// File: rtl/drive_command_ctrl.sv
// Drive command stage: accepts motion commands, ramps per-side speed levels, sequences
// direction changes through a stop, generates per-motor PWM and latches overcurrent faults.
module drive_command_ctrl #(
  parameter int unsigned RAMP_TICKS = 1_000_000,
  parameter int unsigned OC_FILTER  = 16,
  parameter int unsigned PWM_DIV    = 1000
) (
  input logic                 clock,
  input logic                 reset,
  drive_command_ctrl_if.slave bus
);

  localparam int unsigned RampW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
  localparam int unsigned PwmW  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int unsigned OcW   = $clog2(OC_FILTER + 1);

  localparam logic [3:0] DirStop  = 4'b0000;
  localparam logic [3:0] DirFwd   = 4'b1001;
  localparam logic [3:0] DirBack  = 4'b0110;
  localparam logic [3:0] DirLeft  = 4'b0101;
  localparam logic [3:0] DirRight = 4'b1010;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFault} state_e;

  state_e           state_q, state_d;
  logic [3:0]       dir_q, dir_d;
  logic [2:0]       tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
  logic [2:0]       spd_l_q, spd_l_d, spd_r_q, spd_r_d;
  logic [3:0]       pend_dir_q, pend_dir_d;
  logic [2:0]       pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [RampW-1:0] ramp_cnt_q, ramp_cnt_d;
  logic [PwmW-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [2:0]       phase_q, phase_d;
  logic             oc_s1_q, oc_s1_d, oc_s2_q, oc_s2_d;
  logic [OcW-1:0]   oc_cnt_q, oc_cnt_d;
  logic             fault_q, fault_d;
  logic             pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;

  logic       ready;
  logic       accept;
  logic       load;
  logic       oc_trip;
  logic       ramp_wrap;
  logic       slot_wrap;
  logic       speeds_zero;
  logic [3:0] in_dir;
  logic [2:0] in_l, in_r;

  function automatic logic [2:0] step_toward(input logic [2:0] cur, input logic [2:0] tgt);
    if (cur < tgt) begin
      return cur + 3'd1;
    end else if (cur > tgt) begin
      return cur - 3'd1;
    end
    return cur;
  endfunction

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    tgt_l_d    = tgt_l_q;
    tgt_r_d    = tgt_r_q;
    spd_l_d    = spd_l_q;
    spd_r_d    = spd_r_q;
    pend_dir_d = pend_dir_q;
    pend_l_d   = pend_l_q;
    pend_r_d   = pend_r_q;
    fault_d    = fault_q;
    load       = 1'b0;

    oc_s1_d = bus.oc_left;
    oc_s2_d = oc_s1_q;
    if (!oc_s2_q) begin
      oc_cnt_d = '0;
    end else if (oc_cnt_q == OcW'(OC_FILTER)) begin
      oc_cnt_d = oc_cnt_q;
    end else begin
      oc_cnt_d = oc_cnt_q + 1'b1;
    end
    // Trip on the cycle the consecutive-high count reaches the filter length.
    oc_trip = oc_s2_q && (oc_cnt_q >= OcW'(OC_FILTER - 1));

    ramp_wrap  = (ramp_cnt_q == RampW'(RAMP_TICKS - 1));
    ramp_cnt_d = ramp_wrap ? '0 : ramp_cnt_q + 1'b1;
    slot_wrap  = (pwm_cnt_q == PwmW'(PWM_DIV - 1));
    pwm_cnt_d  = slot_wrap ? '0 : pwm_cnt_q + 1'b1;
    phase_d    = phase_q;
    if (slot_wrap) begin
      phase_d = (phase_q == 3'd6) ? 3'd0 : phase_q + 3'd1;
    end

    unique case (bus.cmd_dir)
      DirFwd, DirBack, DirLeft, DirRight: in_dir = bus.cmd_dir;
      default:                            in_dir = DirStop;
    endcase
    in_l = (in_dir == DirStop) ? 3'd0 : bus.cmd_speedL;
    in_r = (in_dir == DirStop) ? 3'd0 : bus.cmd_speedR;

    ready       = (state_q == StIdle) || (state_q == StRun);
    accept      = bus.cmd_valid && ready;
    speeds_zero = (spd_l_q == 3'd0) && (spd_r_q == 3'd0);

    unique case (state_q)
      StIdle, StRun: begin
        if (accept) begin
          load = 1'b1;
          if ((in_dir == dir_q) || speeds_zero) begin
            dir_d   = in_dir;
            tgt_l_d = in_l;
            tgt_r_d = in_r;
            state_d = StRun;
          end else begin
            tgt_l_d    = 3'd0;
            tgt_r_d    = 3'd0;
            pend_dir_d = in_dir;
            pend_l_d   = in_l;
            pend_r_d   = in_r;
            state_d    = StDrain;
          end
        end else if ((state_q == StRun) && (dir_q == DirStop) && speeds_zero) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (speeds_zero) begin
          load    = 1'b1;
          dir_d   = pend_dir_q;
          tgt_l_d = pend_l_q;
          tgt_r_d = pend_r_q;
          state_d = StRun;
        end
      end
      StFault: begin
        if (bus.fault_clear && !oc_s2_q) begin
          state_d = StIdle;
          fault_d = 1'b0;
        end
      end
    endcase

    // A cycle that loads new targets skips its ramp step, so the first move waits a wrap.
    if (ramp_wrap && !load) begin
      spd_l_d = step_toward(spd_l_q, tgt_l_q);
      spd_r_d = step_toward(spd_r_q, tgt_r_q);
    end

    if (oc_trip) begin
      state_d    = StFault;
      fault_d    = 1'b1;
      spd_l_d    = 3'd0;
      spd_r_d    = 3'd0;
      tgt_l_d    = 3'd0;
      tgt_r_d    = 3'd0;
      dir_d      = DirStop;
      pend_dir_d = DirStop;
      pend_l_d   = 3'd0;
      pend_r_d   = 3'd0;
    end

    pwm_l_d = (phase_d < spd_l_d);
    pwm_r_d = (phase_d < spd_r_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      dir_q      <= DirStop;
      tgt_l_q    <= 3'd0;
      tgt_r_q    <= 3'd0;
      spd_l_q    <= 3'd0;
      spd_r_q    <= 3'd0;
      pend_dir_q <= DirStop;
      pend_l_q   <= 3'd0;
      pend_r_q   <= 3'd0;
      ramp_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      phase_q    <= 3'd0;
      oc_s1_q    <= 1'b0;
      oc_s2_q    <= 1'b0;
      oc_cnt_q   <= '0;
      fault_q    <= 1'b0;
      pwm_l_q    <= 1'b0;
      pwm_r_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      tgt_l_q    <= tgt_l_d;
      tgt_r_q    <= tgt_r_d;
      spd_l_q    <= spd_l_d;
      spd_r_q    <= spd_r_d;
      pend_dir_q <= pend_dir_d;
      pend_l_q   <= pend_l_d;
      pend_r_q   <= pend_r_d;
      ramp_cnt_q <= ramp_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      phase_q    <= phase_d;
      oc_s1_q    <= oc_s1_d;
      oc_s2_q    <= oc_s2_d;
      oc_cnt_q   <= oc_cnt_d;
      fault_q    <= fault_d;
      pwm_l_q    <= pwm_l_d;
      pwm_r_q    <= pwm_r_d;
    end
  end

  assign bus.cmd_ready  = ready;
  assign bus.speedLeft  = spd_l_q;
  assign bus.speedRight = spd_r_q;
  assign bus.direction  = dir_q;
  assign bus.fault      = fault_q;
  assign bus.pwm_left   = pwm_l_q;
  assign bus.pwm_right  = pwm_r_q;

endmodule

// File: tb/tb_drive_command_ctrl.sv
// Directed bench for drive_command_ctrl with a fast ramp (4 clocks) and PWM slot (2 clocks).
module tb_drive_command_ctrl;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  drive_command_ctrl_if bus ();

  drive_command_ctrl #(
    .RAMP_TICKS(4),
    .OC_FILTER (16),
    .PWM_DIV   (2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] dir;
    logic [2:0] l;
    logic [2:0] r;
    logic [3:0] exp_dir;
    logic [2:0] exp_l;
    logic [2:0] exp_r;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic [2:0] l, input logic [2:0] r);
    int guard = 0;
    while (!bus.cmd_ready && guard < 200) begin
      step();
      guard++;
    end
    if (!bus.cmd_ready) check("send_ready_timeout", 0, 1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_dir    = d;
    bus.cmd_speedL = l;
    bus.cmd_speedR = r;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_speeds(input logic [2:0] l, input logic [2:0] r, input int budget,
                             output int cyc);
    cyc = 0;
    while (!(bus.speedLeft == l && bus.speedRight == r) && cyc < budget) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int t_l, t_r, viol, hi_l, hi_r, dec_l, dec_r;
    logic [2:0] prev_l, prev_r;

    vecs[0] = '{4'b1001, 3'd7, 3'd0, 4'b1001, 3'd7, 3'd0};
    vecs[1] = '{4'b0101, 3'd2, 3'd4, 4'b0101, 3'd2, 3'd4};
    vecs[2] = '{4'b0101, 3'd0, 3'd0, 4'b0101, 3'd0, 3'd0};
    vecs[3] = '{4'b1010, 3'd6, 3'd1, 4'b1010, 3'd6, 3'd1};
    vecs[4] = '{4'b0011, 3'd5, 3'd5, 4'b0000, 3'd0, 3'd0};
    vecs[5] = '{4'b0110, 3'd1, 3'd7, 4'b0110, 3'd1, 3'd7};
    vecs[6] = '{4'b0000, 3'd4, 3'd4, 4'b0000, 3'd0, 3'd0};
    vecs[7] = '{4'b1111, 3'd3, 3'd3, 4'b0000, 3'd0, 3'd0};

    bus.cmd_valid   = 1'b0;
    bus.cmd_dir     = 4'b0000;
    bus.cmd_speedL  = 3'd0;
    bus.cmd_speedR  = 3'd0;
    bus.oc_left     = 1'b0;
    bus.fault_clear = 1'b0;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_speeds", {bus.speedLeft, bus.speedRight}, 0);
    check("rst_dir", bus.direction, 0);
    check("rst_fault", bus.fault, 0);
    check("rst_pwm", {bus.pwm_left, bus.pwm_right}, 0);

    // Forward 5/3 from idle: direction after one cycle, right reaches 3 two wraps before left hits 5.
    send(4'b1001, 3'd5, 3'd3);
    check("fwd_dir_next_cycle", bus.direction, 4'b1001);
    t_l = -1; t_r = -1; viol = 0;
    prev_l = bus.speedLeft; prev_r = bus.speedRight;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (bus.speedLeft > prev_l + 3'd1 || bus.speedLeft < prev_l || bus.speedLeft > 3'd5) viol++;
      if (bus.speedRight > prev_r + 3'd1 || bus.speedRight < prev_r || bus.speedRight > 3'd3)
        viol++;
      if (t_r < 0 && bus.speedRight == 3'd3) t_r = c;
      if (t_l < 0 && bus.speedLeft == 3'd5) t_l = c;
      prev_l = bus.speedLeft; prev_r = bus.speedRight;
    end
    check("fwd_ramp_steps", viol, 0);
    check("fwd_r3_window", (t_r >= 9 && t_r <= 12), 1);
    check("fwd_l_minus_r", t_l - t_r, 8);
    check("fwd_final", {bus.speedLeft, bus.speedRight}, {3'd5, 3'd3});

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].dir, vecs[i].l, vecs[i].r);
      step(100);
      check($sformatf("tbl%0d_dir", i), bus.direction, vecs[i].exp_dir);
      check($sformatf("tbl%0d_spdl", i), bus.speedLeft, vecs[i].exp_l);
      check($sformatf("tbl%0d_spdr", i), bus.speedRight, vecs[i].exp_r);
      check($sformatf("tbl%0d_ready", i), bus.cmd_ready, 1);
    end

    // Reversal: drain to stop under the old direction, then ramp up under the new one.
    send(4'b1001, 3'd5, 3'd5);
    wait_speeds(3'd5, 3'd5, 100, cyc);
    check("drain_pre_reached", (cyc < 100), 1);
    send(4'b0110, 3'd2, 3'd2);
    check("drain_ready_low", bus.cmd_ready, 0);
    check("drain_dir_held", bus.direction, 4'b1001);
    viol = 0; dec_l = 0; dec_r = 0; cyc = 0;
    prev_l = bus.speedLeft; prev_r = bus.speedRight;
    while (bus.direction != 4'b0110 && cyc < 100) begin
      step();
      cyc++;
      if (bus.direction != 4'b0110) begin
        if (bus.direction != 4'b1001 || bus.cmd_ready) viol++;
        if (bus.speedLeft > prev_l || bus.speedRight > prev_r) viol++;
        if (bus.speedLeft < prev_l) dec_l++;
        if (bus.speedRight < prev_r) dec_r++;
        prev_l = bus.speedLeft; prev_r = bus.speedRight;
      end
    end
    check("drain_dir_switch", bus.direction, 4'b0110);
    check("drain_speeds_at_switch", {bus.speedLeft, bus.speedRight}, 0);
    check("drain_monotone", viol, 0);
    check("drain_steps", {dec_l[7:0], dec_r[7:0]}, {8'd5, 8'd5});
    wait_speeds(3'd2, 3'd2, 100, cyc);
    check("drain_post_speeds", {bus.speedLeft, bus.speedRight}, {3'd2, 3'd2});
    check("drain_post_ready", bus.cmd_ready, 1);

    // PWM duty over four full 14-clock periods.
    send(4'b1001, 3'd3, 3'd7);
    wait_speeds(3'd3, 3'd7, 100, cyc);
    hi_l = 0; hi_r = 0;
    for (int c = 0; c < 56; c++) begin
      step();
      hi_l += int'(bus.pwm_left);
      hi_r += int'(bus.pwm_right);
    end
    check("pwm_speed3_highs", hi_l, 24);
    check("pwm_speed7_highs", hi_r, 56);
    send(4'b0000, 3'd0, 3'd0);
    wait_speeds(3'd0, 3'd0, 100, cyc);
    step(8);
    hi_l = 0; hi_r = 0;
    for (int c = 0; c < 56; c++) begin
      step();
      hi_l += int'(bus.pwm_left);
      hi_r += int'(bus.pwm_right);
    end
    check("pwm_speed0_highs", hi_l + hi_r, 0);
    check("stop_dir", bus.direction, 0);

    // Overcurrent filter: 15 highs or a broken run must not trip.
    send(4'b1001, 3'd4, 3'd4);
    wait_speeds(3'd4, 3'd4, 100, cyc);
    bus.oc_left = 1'b1;
    step(15);
    bus.oc_left = 1'b0;
    step(20);
    check("oc15_no_fault", bus.fault, 0);
    bus.oc_left = 1'b1;
    step(10);
    bus.oc_left = 1'b0;
    step();
    bus.oc_left = 1'b1;
    step(10);
    bus.oc_left = 1'b0;
    step(20);
    check("oc_gap_no_fault", bus.fault, 0);
    check("oc_gap_speeds_kept", {bus.speedLeft, bus.speedRight}, {3'd4, 3'd4});
    bus.oc_left = 1'b1;
    cyc = 0;
    while (!bus.fault && cyc < 40) begin
      step();
      cyc++;
    end
    check("oc_fault_set", bus.fault, 1);
    check("oc_fault_speeds", {bus.speedLeft, bus.speedRight}, 0);
    check("oc_fault_dir", bus.direction, 0);
    check("oc_fault_pwm", {bus.pwm_left, bus.pwm_right}, 0);
    check("oc_fault_ready", bus.cmd_ready, 0);

    // In FAULT commands are ignored and clear needs oc low.
    bus.cmd_valid = 1'b1;
    bus.cmd_dir = 4'b1001;
    bus.cmd_speedL = 3'd3;
    bus.cmd_speedR = 3'd3;
    step(3);
    bus.cmd_valid = 1'b0;
    step(12);
    check("fault_cmd_ignored", {bus.direction, bus.speedLeft, bus.speedRight}, 0);
    bus.fault_clear = 1'b1;
    step();
    bus.fault_clear = 1'b0;
    step(2);
    check("fault_clear_oc_high", bus.fault, 1);
    bus.oc_left = 1'b0;
    step(4);
    bus.fault_clear = 1'b1;
    step();
    bus.fault_clear = 1'b0;
    check("fault_cleared", bus.fault, 0);
    check("fault_cleared_ready", bus.cmd_ready, 1);
    send(4'b1001, 3'd1, 3'd1);
    wait_speeds(3'd1, 3'd1, 100, cyc);
    check("post_fault_run", {bus.direction, bus.speedLeft, bus.speedRight},
          {4'b1001, 3'd1, 3'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
